key_debounce: RTL

Debounces the board push-buttons (key_in, key_out, key_cnt) before they reach the router control logic. Each button is active-low and bounces. The block synchronises each button, filters it through a per-key stability counter, and emits a clean pressed level plus single-cycle press and release pulses. It sits directly upstream of router_top's key handling, and one instance serves all keys.

---
 rtl/key_debounce.sv | 127 ++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce: per-key synchroniser + stability-counter FSM producing clean level, press/release pulses.
// Optional hold detection with long-press pulse when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [NUM_KEYS-1:0] key_n_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    // The edge leaving RELEASED/PRESSED is the first stable cycle, so the check ends one count early.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES >= 2 ? DEBOUNCE_CYCLES - 2 : 0);
    localparam bit SHORT = DEBOUNCE_CYCLES == 1;

    typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

    logic [NUM_KEYS-1:0] sync1, sync2, s;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n_in;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        state_t state, state_nx;
        logic [CW-1:0] cnt, cnt_nx;
        logic press_nx, release_nx, press_q, release_q, level;

        always_ff @(posedge clk) begin
            if (!nreset) begin
                state     <= RELEASED;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nx;
                cnt       <= cnt_nx;
                press_q   <= press_nx;
                release_q <= release_nx;
            end
        end

        always_comb begin
            state_nx   = state;
            cnt_nx     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            press_nx   = 1'b0;
            release_nx = 1'b0;
            case (state)
                RELEASED: begin
                    cnt_nx = '0;
                    if (s[k]) begin
                        state_nx = SHORT ? PRESSED : PRESS_CHK;
                        press_nx = SHORT;
                    end
                end
                PRESS_CHK: begin
                    if (!s[k]) begin
                        state_nx = RELEASED;
                        cnt_nx   = '0;
                    end else if (cnt >= LAST) begin
                        state_nx = PRESSED;
                        press_nx = 1'b1;
                        cnt_nx   = '0;
                    end
                end
                PRESSED: begin
                    cnt_nx = '0;
                    if (!s[k]) begin
                        state_nx   = SHORT ? RELEASED : RELEASE_CHK;
                        release_nx = SHORT;
                    end
                end
                RELEASE_CHK: begin
                    if (s[k]) begin
                        state_nx = PRESSED;
                        cnt_nx   = '0;
                    end else if (cnt >= LAST) begin
                        state_nx   = RELEASED;
                        release_nx = 1'b1;
                        cnt_nx     = '0;
                    end
                end
            endcase
        end

        assign level          = (state == PRESSED) || (state == RELEASE_CHK);
        assign key_level[k]   = level;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;

`ifdef KEY_LONG_PRESS_EN
        localparam int LW = $clog2(LONG_CYCLES + 1);
        localparam logic [LW-1:0] LMAX = LW'(LONG_CYCLES);
        logic [LW-1:0] hold;
        logic long_q;

        // Hold time keeps running through a release check; only a new press restarts it.
        always_ff @(posedge clk) begin
            if (!nreset) begin
                hold   <= '0;
                long_q <= 1'b0;
            end else begin
                hold   <= press_nx ? '0 : (level && hold != LMAX) ? hold + 1'b1 : hold;
                long_q <= level && hold == LMAX - 1'b1;
            end
        end

        assign key_long[k] = long_q;
`else
        assign key_long[k] = 1'b0;
`endif
    end
endmodule
